// File: rtl/evp_pkg.sv
// Shared constants, field positions and FSM state type for the EVP command controller.
package evp_pkg;

  localparam int unsigned SLOTS   = 8;
  localparam int unsigned MAX_N   = 16;
  localparam int unsigned CW      = 16;
  localparam int unsigned TIMEOUT = 1024;

  localparam int unsigned SLOT_W = 3;
  localparam int unsigned N_W    = 5;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned WDOG_W = 10;

  localparam int unsigned OP_LSB   = 29;
  localparam int unsigned SLOT_LSB = 26;
  localparam int unsigned N_LSB    = 21;
  localparam int unsigned PAY_LSB  = 0;

  localparam logic [2:0] OP_STS = 3'b000;
  localparam logic [2:0] OP_EVP = 3'b001;
  localparam logic [2:0] OP_CLR = 3'b010;

  localparam logic [31:0] ST_OK      = 32'd0;
  localparam logic [31:0] ST_BADOP   = 32'd1;
  localparam logic [31:0] ST_BADN    = 32'd2;
  localparam logic [31:0] ST_EMPTY   = 32'd3;
  localparam logic [31:0] ST_TIMEOUT = 32'd4;

  localparam logic [N_W-1:0]    N_LIMIT   = N_W'(MAX_N);
  localparam logic [IDX_W-1:0]  CIDX_LAST = IDX_W'(MAX_N - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_CAPTURE,
    S_RESPOND
  } evp_state_t;

endpackage

// File: rtl/evp_coef_bank.sv
// Coefficient register file: SLOTS x MAX_N x CW, one write port, one async read port,
// plus per-slot valid bit and stored coefficient count.
module evp_coef_bank
  import evp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [SLOT_W-1:0] slot,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [CW-1:0]     wr_data,
  input  logic              set_valid,
  input  logic [N_W-1:0]    set_n,
  input  logic              clr_valid,
  output logic              slot_valid,
  output logic [N_W-1:0]    slot_n,
  input  logic [SLOT_W-1:0] rd_slot,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [CW-1:0]     rd_data
);

  logic [CW-1:0]    coef  [SLOTS][MAX_N];
  logic [N_W-1:0]   n_tab [SLOTS];
  logic [SLOTS-1:0] valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < SLOTS; s++) begin
        n_tab[s] <= '0;
        for (int unsigned i = 0; i < MAX_N; i++) coef[s][i] <= '0;
      end
      valid <= '0;
    end else begin
      if (we) coef[slot][wr_idx] <= wr_data;
      if (set_valid) begin
        valid[slot] <= 1'b1;
        n_tab[slot] <= set_n;
      end else if (clr_valid) begin
        valid[slot] <= 1'b0;
      end
    end
  end

  assign slot_valid = valid[slot];
  assign slot_n     = n_tab[slot];
  assign rd_data    = coef[rd_slot][rd_idx];

endmodule

// File: rtl/evp_cmd_controller.sv
// Command sequencer for the polynomial evaluation engine (STS/EVP/CLR, start_evp/done_evp).
// Define EVP_TIMEOUT_EN to add a WAIT-state watchdog returning status 4.
module evp_cmd_controller
  import evp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [31:0]       rsp_result,
  output logic [31:0]       rsp_status,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              start_evp,
  output logic [SLOT_W-1:0] evp_A,
  output logic [CW-1:0]     evp_x,
  output logic [N_W-1:0]    evp_N,
  output logic [CW-1:0]     evp_c_i,
  input  logic              en_rd_data,
  input  logic              en_rd_S,
  input  logic              en_rd_N,
  input  logic              done_evp,
  input  logic [31:0]       evp_result,
  input  logic [31:0]       evp_status
);

  evp_state_t state, state_n;

  logic              run_q;
  logic [2:0]        op_q;
  logic [SLOT_W-1:0] slot_q;
  logic [N_W-1:0]    n_q;
  logic [CW-1:0]     x_q;
  logic [N_W-1:0]    k_q;
  logic [IDX_W-1:0]  cidx;

  logic              bank_we, set_valid, clr_valid, rsp_load;
  logic              slot_valid;
  logic [N_W-1:0]    slot_n;
  logic [31:0]       res_n, st_n;
  logic              accept;

`ifdef EVP_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{en_rd_data, cmd_data[20:16]};

  evp_coef_bank u_bank (
    .clk        (clk),
    .rst        (rst),
    .slot       (slot_q),
    .we         (bank_we),
    .wr_idx     (k_q[IDX_W-1:0]),
    .wr_data    (cmd_data[PAY_LSB +: CW]),
    .set_valid  (set_valid),
    .set_n      (n_q),
    .clr_valid  (clr_valid),
    .slot_valid (slot_valid),
    .slot_n     (slot_n),
    .rd_slot    (evp_A),
    .rd_idx     (cidx),
    .rd_data    (evp_c_i)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // run_q keeps cmd_ready low while reset is asserted even though the FSM sits in IDLE.
  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    start_evp = 1'b0;
    rsp_valid = 1'b0;
    bank_we   = 1'b0;
    set_valid = 1'b0;
    clr_valid = 1'b0;
    rsp_load  = 1'b0;
    res_n     = '0;
    st_n      = ST_OK;
    unique case (state)
      S_IDLE: begin
        cmd_ready = run_q;
        if (run_q && cmd_valid) state_n = S_DECODE;
      end
      S_DECODE: begin
        unique case (op_q)
          OP_STS: begin
            if (n_q != '0 && n_q <= N_LIMIT) begin
              clr_valid = 1'b1;
              state_n   = S_LOAD;
            end else begin
              rsp_load = 1'b1;
              st_n     = ST_BADN;
              state_n  = S_RESPOND;
            end
          end
          OP_EVP: begin
            if (slot_valid) begin
              state_n = S_START;
            end else begin
              rsp_load = 1'b1;
              st_n     = ST_EMPTY;
              state_n  = S_RESPOND;
            end
          end
          OP_CLR: begin
            clr_valid = 1'b1;
            rsp_load  = 1'b1;
            state_n   = S_RESPOND;
          end
          default: begin
            rsp_load = 1'b1;
            st_n     = ST_BADOP;
            state_n  = S_RESPOND;
          end
        endcase
      end
      S_LOAD: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          bank_we = 1'b1;
          if (k_q == n_q - 5'd1) begin
            set_valid = 1'b1;
            rsp_load  = 1'b1;
            state_n   = S_RESPOND;
          end
        end
      end
      S_START: begin
        start_evp = 1'b1;
        state_n   = S_WAIT;
      end
      S_WAIT: begin
        if (done_evp) begin
          state_n = S_CAPTURE;
        end
`ifdef EVP_TIMEOUT_EN
        else if (wdog == WDOG_LAST) begin
          rsp_load = 1'b1;
          st_n     = ST_TIMEOUT;
          state_n  = S_RESPOND;
        end
`endif
      end
      S_CAPTURE: begin
        rsp_load = 1'b1;
        res_n    = evp_result;
        st_n     = evp_status;
        state_n  = S_RESPOND;
      end
      S_RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign accept = (state == S_IDLE) && cmd_ready && cmd_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      op_q       <= '0;
      slot_q     <= '0;
      n_q        <= '0;
      x_q        <= '0;
      k_q        <= '0;
      cidx       <= '0;
      evp_A      <= '0;
      evp_x      <= '0;
      evp_N      <= '0;
      rsp_result <= '0;
      rsp_status <= '0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        op_q   <= cmd_data[OP_LSB +: 3];
        slot_q <= cmd_data[SLOT_LSB +: SLOT_W];
        n_q    <= cmd_data[N_LSB +: N_W];
        x_q    <= cmd_data[PAY_LSB +: CW];
        k_q    <= '0;
      end
      if (bank_we) k_q <= k_q + 5'd1;
      if (state == S_DECODE && state_n == S_START) begin
        evp_A <= slot_q;
        evp_x <= x_q;
        evp_N <= slot_n;
      end
      if (state == S_START) begin
        cidx <= '0;
      end else if (state == S_WAIT) begin
        if (en_rd_S && en_rd_N)                 cidx <= '0;
        else if (en_rd_S && cidx != CIDX_LAST)  cidx <= cidx + 4'd1;
      end
      if (rsp_load) begin
        rsp_result <= res_n;
        rsp_status <= st_n;
      end
    end
  end

`ifdef EVP_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 wdog <= '0;
    else if (state == S_START) wdog <= '0;
    else if (state == S_WAIT)  wdog <= wdog + 10'd1;
  end
`endif

endmodule
